// File: rtl/op_timer_pkg.sv
// Shared types and helpers for the operation-latency timer.
package op_timer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int OP_TIMER_LAT_W       = 4;
  localparam int OP_TIMER_DEFAULT_LAT = 2;

  // A zero latency request selects the configured default.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned dflt);
    return (lat == 0) ? dflt : lat;
  endfunction

endpackage

// File: rtl/op_timer_if.sv
// Sequencer-to-timer bundle: request/control inputs and status outputs.
interface op_timer_if
  import op_timer_pkg::*;
#(
  parameter int LAT_W = OP_TIMER_LAT_W
);

  // Handshake: start is a request with no ready. It is taken on any edge where
  // the timer is idle and abort is low (busy is high the cycle after). A start
  // arriving while busy, and not alongside abort, is ignored and answered with
  // a one-cycle start_drop. lat_in and periodic are only meaningful with start.
  logic             count_en;
  logic             start;
  logic [LAT_W-1:0] lat_in;
  logic             periodic;
  logic             abort;
  logic             busy;
  logic             op_done;
  logic [LAT_W-1:0] remaining;
  logic             start_drop;
  state_t           fsm_state;

  modport master (
    output count_en, start, lat_in, periodic, abort,
    input  busy, op_done, remaining, start_drop, fsm_state
  );

  modport slave (
    input  count_en, start, lat_in, periodic, abort,
    output busy, op_done, remaining, start_drop, fsm_state
  );

endinterface

// File: rtl/op_timer.sv
// Programmable-latency done generator with one-shot/periodic modes, stall,
// abort and dropped-start reporting.
module op_timer
  import op_timer_pkg::*;
#(
  parameter int LAT_W       = OP_TIMER_LAT_W,
  parameter int DEFAULT_LAT = OP_TIMER_DEFAULT_LAT
) (
  input  logic       clock,
  input  logic       reset,
  op_timer_if.slave  bus
);

  if (DEFAULT_LAT < 1 || DEFAULT_LAT > (2 ** LAT_W) - 1) begin : g_bad_default
    $error("op_timer: DEFAULT_LAT out of range 1..2^LAT_W-1");
  end

  state_t           state, state_n;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic [LAT_W-1:0] lat_q, lat_n;
  logic             mode_q, mode_n;
  logic             done_q, done_n;
  logic             drop_q, drop_n;
  logic [LAT_W-1:0] lat_l;

  assign lat_l = LAT_W'(clamp_lat(32'(bus.lat_in), 32'(DEFAULT_LAT)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lat_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      lat_q  <= lat_n;
      mode_q <= mode_n;
      done_q <= done_n;
      drop_q <= drop_n;
    end
  end

  // Priority: abort, then terminal done/reload, then start, then counting.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lat_n   = lat_q;
    mode_n  = mode_q;
    done_n  = 1'b0;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          lat_n   = lat_l;
          mode_n  = bus.periodic;
          cnt_n   = lat_l - LAT_W'(1);
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (bus.abort) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          drop_n = bus.start;
          if (bus.count_en) begin
            if (cnt == '0) begin
              done_n = 1'b1;
              if (mode_q) begin
                cnt_n = lat_q - LAT_W'(1);
              end else begin
                state_n = IDLE;
              end
            end else begin
              cnt_n = cnt - LAT_W'(1);
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.busy       = (state == COUNT);
  assign bus.op_done    = done_q;
  assign bus.remaining  = cnt;
  assign bus.start_drop = drop_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_op_timer.sv
// Directed bench for op_timer: latency, modes, stall, abort, drop and async reset.
module tb_op_timer;
  import op_timer_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  op_timer_if #(.LAT_W(4)) bus ();

  op_timer #(.LAT_W(4), .DEFAULT_LAT(2)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input int b, input int d, input int r, input int s);
    check({tag, ".busy"},       32'(bus.busy),       32'(b));
    check({tag, ".op_done"},    32'(bus.op_done),    32'(d));
    check({tag, ".remaining"},  32'(bus.remaining),  32'(r));
    check({tag, ".start_drop"}, 32'(bus.start_drop), 32'(s));
  endtask

  // Launch a one-shot and follow it to its single done pulse.
  task automatic run_oneshot(input string tag, input int lat, input int l);
    bus.start = 1'b1; bus.lat_in = 4'(lat); bus.periodic = 1'b0;
    step();
    bus.start = 1'b0; bus.lat_in = 4'd0;
    for (int j = 0; j < l; j++) begin
      check_out(tag, 1, 0, l - 1 - j, 0);
      step();
    end
    check_out({tag, ".done"}, 0, 1, 0, 0);
    step();
    check_out({tag, ".after"}, 0, 0, 0, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.count_en = 1'b1; bus.start = 1'b1; bus.lat_in = 4'd5;
    bus.periodic = 1'b0; bus.abort = 1'b0;

    // Reset held with a start request present.
    repeat (3) step();
    check_out("reset", 0, 0, 0, 0);
    check("reset.state", 32'(bus.fsm_state), 32'(IDLE));
    bus.start = 1'b0;
    rst_n = 1'b1;
    step();
    check_out("post_reset", 0, 0, 0, 0);

    // Latency sweep including the default and the extremes.
    run_oneshot("lat5", 5, 5);
    run_oneshot("lat0_default", 0, 2);
    run_oneshot("lat1", 1, 1);
    run_oneshot("lat15", 15, 15);

    // Periodic L=3: ten periods of three cycles.
    bus.start = 1'b1; bus.lat_in = 4'd3; bus.periodic = 1'b1;
    step();
    bus.start = 1'b0; bus.lat_in = 4'd0; bus.periodic = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      check_out("periodic", 1, (e > 0 && e % 3 == 0) ? 1 : 0, 2 - (e % 3), 0);
      if (e < 30) step();
    end
    step();
    check_out("per_e31", 1, 0, 1, 0);
    bus.count_en = 1'b0;
    step();
    check_out("stall1", 1, 0, 1, 0);
    step();
    check_out("stall2", 1, 0, 1, 0);
    bus.count_en = 1'b1;
    step();
    check_out("per_e34", 1, 0, 0, 0);
    step();
    check_out("per_stretched_done", 1, 1, 2, 0);
    step();
    check_out("per_e36", 1, 0, 1, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_out("per_abort", 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_out("per_after_abort", 0, 0, 0, 0);
    end

    // Back-to-back: second start in the op_done cycle of a one-shot.
    bus.start = 1'b1; bus.lat_in = 4'd4;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    check_out("b2b_last", 1, 0, 0, 0);
    step();
    check_out("b2b_done1", 0, 1, 0, 0);
    bus.start = 1'b1; bus.lat_in = 4'd2;
    step();
    bus.start = 1'b0;
    check_out("b2b_accept", 1, 0, 1, 0);
    step();
    check_out("b2b_mid", 1, 0, 0, 0);
    step();
    check_out("b2b_done2", 0, 1, 0, 0);

    // Start while busy is dropped; the running one-shot is untouched.
    bus.start = 1'b1; bus.lat_in = 4'd6;
    step();
    bus.start = 1'b0;
    step();
    step();
    check_out("drop_pre", 1, 0, 3, 0);
    bus.start = 1'b1; bus.lat_in = 4'd9; bus.periodic = 1'b1;
    step();
    bus.start = 1'b0; bus.lat_in = 4'd0; bus.periodic = 1'b0;
    check_out("drop_pulse", 1, 0, 2, 1);
    step();
    check_out("drop_once", 1, 0, 1, 0);
    step();
    check_out("drop_last", 1, 0, 0, 0);
    step();
    check_out("drop_done", 0, 1, 0, 0);
    step();
    check_out("drop_oneshot_kept", 0, 0, 0, 0);

    // Abort on the terminal edge suppresses the done.
    bus.start = 1'b1; bus.lat_in = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    step();
    check_out("tabort_pre", 1, 0, 0, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_out("tabort", 0, 0, 0, 0);
    step();
    check_out("tabort_after", 0, 0, 0, 0);

    // Abort together with start in IDLE: nothing happens.
    bus.abort = 1'b1; bus.start = 1'b1; bus.lat_in = 4'd5;
    step();
    bus.abort = 1'b0; bus.start = 1'b0;
    check_out("abort_start_idle", 0, 0, 0, 0);

    // Async reset between edges during a count.
    bus.start = 1'b1; bus.lat_in = 4'd7;
    step();
    bus.start = 1'b0; bus.lat_in = 4'd0;
    check_out("areset_pre", 1, 0, 6, 0);
    #2 rst_n = 1'b0;
    #1 check_out("areset_now", 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_out("areset_after", 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
